// File: rtl/ysyx_210544_cmt_u_pkg.sv
// Shared constants and types for the commit unit slice.
// Pure declarations, no logic or latency.
// No handshakes here; the package only fixes widths and encodings.
package ysyx_210544_cmt_u_pkg;

    localparam int XLEN      = 64;
    localparam int ILEN      = 32;
    localparam int REG_IDX_W = 5;
    localparam int NUM_GPR   = 32;
    localparam int NUM_CSR   = 16;
    localparam int A0_IDX    = 10;

    localparam logic [ILEN-1:0] HALT_INST = 32'h0000006b;

    // One registered retirement record, as reported to the checker.
    typedef struct packed {
        logic                 valid;
        logic [XLEN-1:0]      pc;
        logic [ILEN-1:0]      inst;
        logic                 wen;
        logic [REG_IDX_W-1:0] wdest;
        logic [XLEN-1:0]      wdata;
        logic                 skip;
    } cmt_rec_t;

    // x0 is hardwired, so a write to it is never architecturally visible.
    function automatic logic eff_wen(input logic wen, input logic [REG_IDX_W-1:0] rd);
        return wen & (rd != '0);
    endfunction

endpackage

// File: rtl/ysyx_210544_cmt_u_if.sv
// Commit bus between write-back and the commit unit.
// Carries the retiring record in and the registered record/counters out.
// No backpressure: the slave accepts one record every cycle.
interface ysyx_210544_cmt_u_if;
    import ysyx_210544_cmt_u_pkg::*;

    logic                          i_cmtvalid;
    logic [XLEN-1:0]               i_pc;
    logic [ILEN-1:0]               i_inst;
    logic [REG_IDX_W-1:0]          i_rd;
    logic                          i_rd_wen;
    logic [XLEN-1:0]               i_rd_wdata;
    logic                          i_skipcmt;
    logic [NUM_GPR-1:0][XLEN-1:0]  i_regs;
    logic [NUM_CSR-1:0][XLEN-1:0]  i_csrs;
    logic [31:0]                   i_intrNo;

    logic                          o_valid;
    logic [XLEN-1:0]               o_pc;
    logic [ILEN-1:0]               o_inst;
    logic                          o_wen;
    logic [REG_IDX_W-1:0]          o_wdest;
    logic [XLEN-1:0]               o_wdata;
    logic                          o_skip;
    logic [31:0]                   o_intrNo;
    logic [63:0]                   o_cycle_cnt;
    logic [63:0]                   o_instr_cnt;
    logic                          o_trap;
    logic                          o_trap_good;

    modport master (
        output i_cmtvalid, i_pc, i_inst, i_rd, i_rd_wen, i_rd_wdata,
               i_skipcmt, i_regs, i_csrs, i_intrNo,
        input  o_valid, o_pc, o_inst, o_wen, o_wdest, o_wdata, o_skip,
               o_intrNo, o_cycle_cnt, o_instr_cnt, o_trap, o_trap_good
    );

    modport slave (
        input  i_cmtvalid, i_pc, i_inst, i_rd, i_rd_wen, i_rd_wdata,
               i_skipcmt, i_regs, i_csrs, i_intrNo,
        output o_valid, o_pc, o_inst, o_wen, o_wdest, o_wdata, o_skip,
               o_intrNo, o_cycle_cnt, o_instr_cnt, o_trap, o_trap_good
    );

endinterface

// File: rtl/ysyx_210544_cmt_difftest_if.sv
// Difftest co-simulation hooks, only present when DIFFTEST_COMMIT_EN is defined.
// Inputs are already registered by the commit unit; hooks fire on each clock edge.
// No backpressure: the checker must consume one report per cycle.
`ifdef DIFFTEST_COMMIT_EN
module ysyx_210544_cmt_difftest_if
    import ysyx_210544_cmt_u_pkg::*;
(
    input logic                         clk,
    input cmt_rec_t                     rec_i,
    input logic [NUM_GPR-1:0][XLEN-1:0] regs_i,
    input logic [NUM_CSR-1:0][XLEN-1:0] csrs_i,
    input logic [31:0]                  intr_no_i,
    input logic                         trap_i,
    input logic                         trap_good_i,
    input logic [63:0]                  cycle_cnt_i,
    input logic [63:0]                  instr_cnt_i
);

    byte                          commit_core;
    cmt_rec_t                     commit_rec;
    byte                          gpr_core;
    logic [NUM_GPR*XLEN-1:0]      gpr_state;
    byte                          csr_core;
    byte                          csr_priv;
    logic [NUM_CSR*XLEN-1:0]      csr_state;
    byte                          event_core;
    int                           event_intr;
    byte                          trap_core;
    logic                         trap_valid;
    logic                         trap_good;
    longint                       trap_cycle;
    longint                       trap_instr;

    function void v_difftest_InstrCommit(
        input byte coreid, input byte index, input bit valid,
        input longint pc, input int instr, input bit skip,
        input bit wen, input byte wdest, input longint wdata);
        commit_core       = coreid;
        commit_rec.valid  = valid;
        commit_rec.pc     = pc;
        commit_rec.inst   = instr;
        commit_rec.skip   = skip;
        commit_rec.wen    = wen;
        commit_rec.wdest  = wdest[REG_IDX_W-1:0];
        commit_rec.wdata  = wdata;
    endfunction

    function void v_difftest_ArchIntRegState(
        input byte coreid, input bit [NUM_GPR*XLEN-1:0] gpr);
        gpr_core  = coreid;
        gpr_state = gpr;
    endfunction

    // CSR vector is packed with index 0 in the least-significant slot.
    function void v_difftest_CSRState(
        input byte coreid, input byte priv_mode, input bit [NUM_CSR*XLEN-1:0] csr);
        csr_core  = coreid;
        csr_priv  = priv_mode;
        csr_state = csr;
    endfunction

    function void v_difftest_ArchEvent(
        input byte coreid, input int intr_no);
        event_core = coreid;
        event_intr = intr_no;
    endfunction

    function void v_difftest_TrapEvent(
        input byte coreid, input bit valid, input bit good,
        input longint cycle_cnt, input longint instr_cnt);
        trap_core  = coreid;
        trap_valid = valid;
        trap_good  = good;
        trap_cycle = cycle_cnt;
        trap_instr = instr_cnt;
    endfunction

    // Report the registered commit state to the checker every cycle, core 0, M-mode.
    always_ff @(posedge clk) begin
        v_difftest_InstrCommit(8'd0, 8'd0, rec_i.valid, rec_i.pc, rec_i.inst,
                               rec_i.skip, rec_i.wen, {3'b000, rec_i.wdest}, rec_i.wdata);
        v_difftest_ArchIntRegState(8'd0, regs_i);
        v_difftest_CSRState(8'd0, 8'd3, csrs_i);
        v_difftest_ArchEvent(8'd0, intr_no_i);
        v_difftest_TrapEvent(8'd0, trap_i, trap_good_i, cycle_cnt_i, instr_cnt_i);
    end

endmodule
`endif

// File: rtl/ysyx_210544_cmt_u.sv
// Commit unit: registers the retiring record, counts cycles/instructions, detects halt (0x6b).
// Latency 1 cycle for every output; trap flags and counters freeze once halt retires until rst.
// No backpressure; optional difftest hooks under DIFFTEST_COMMIT_EN.
module ysyx_210544_cmt_u
    import ysyx_210544_cmt_u_pkg::*;
(
    input logic                clk,
    input logic                rst,
    ysyx_210544_cmt_u_if.slave cmt
);

    cmt_rec_t    rec_q,   rec_d;
    logic [31:0] intr_q;
    logic [63:0] cyc_q,   cyc_d;
    logic [63:0] ins_q,   ins_d;
    logic        trap_q,  trap_d;
    logic        good_q,  good_d;
    logic        halt;

    assign halt = cmt.i_cmtvalid && (cmt.i_inst == HALT_INST);

    // Next-state: capture on commit, count until a halt has retired.
    always_comb begin
        rec_d       = rec_q;
        rec_d.valid = cmt.i_cmtvalid;
        if (cmt.i_cmtvalid) begin
            rec_d.pc    = cmt.i_pc;
            rec_d.inst  = cmt.i_inst;
            rec_d.wen   = eff_wen(cmt.i_rd_wen, cmt.i_rd);
            rec_d.wdest = cmt.i_rd;
            rec_d.wdata = cmt.i_rd_wdata;
            rec_d.skip  = cmt.i_skipcmt;
        end

        cyc_d  = cyc_q;
        ins_d  = ins_q;
        trap_d = trap_q;
        good_d = good_q;
        if (!trap_q) begin
            cyc_d = cyc_q + 64'd1;
            if (cmt.i_cmtvalid) begin
                ins_d = ins_q + 64'd1;
            end
            if (halt) begin
                trap_d = 1'b1;
                good_d = (cmt.i_regs[A0_IDX] == '0);
            end
        end
    end

    // State registers; synchronous reset clears everything including the trap freeze.
    always_ff @(posedge clk) begin
        if (rst) begin
            rec_q  <= '0;
            intr_q <= '0;
            cyc_q  <= '0;
            ins_q  <= '0;
            trap_q <= 1'b0;
            good_q <= 1'b0;
        end else begin
            rec_q  <= rec_d;
            intr_q <= cmt.i_intrNo;
            cyc_q  <= cyc_d;
            ins_q  <= ins_d;
            trap_q <= trap_d;
            good_q <= good_d;
        end
    end

    assign cmt.o_valid     = rec_q.valid;
    assign cmt.o_pc        = rec_q.pc;
    assign cmt.o_inst      = rec_q.inst;
    assign cmt.o_wen       = rec_q.wen;
    assign cmt.o_wdest     = rec_q.wdest;
    assign cmt.o_wdata     = rec_q.wdata;
    assign cmt.o_skip      = rec_q.skip;
    assign cmt.o_intrNo    = intr_q;
    assign cmt.o_cycle_cnt = cyc_q;
    assign cmt.o_instr_cnt = ins_q;
    assign cmt.o_trap      = trap_q;
    assign cmt.o_trap_good = good_q;

`ifdef DIFFTEST_COMMIT_EN
    logic [NUM_GPR-1:0][XLEN-1:0] regs_q;
    logic [NUM_CSR-1:0][XLEN-1:0] csrs_q;

    // Architectural snapshots are aligned with the registered commit record.
    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q <= '0;
            csrs_q <= '0;
        end else begin
            regs_q <= cmt.i_regs;
            csrs_q <= cmt.i_csrs;
        end
    end

    ysyx_210544_cmt_difftest_if u_difftest (
        .clk         (clk),
        .rec_i       (rec_q),
        .regs_i      (regs_q),
        .csrs_i      (csrs_q),
        .intr_no_i   (intr_q),
        .trap_i      (trap_q),
        .trap_good_i (good_q),
        .cycle_cnt_i (cyc_q),
        .instr_cnt_i (ins_q)
    );
`else
    // Without the checker the register snapshots are not kept.
`endif

endmodule

// File: tb/tb_ysyx_210544_cmt_u.sv
// Self-checking bench for the commit unit: scoreboard of expected registered outputs.
// Each driven cycle pushes one expectation, popped and compared one clock later.
// The DUT never stalls, so every cycle produces exactly one result.
module tb_ysyx_210544_cmt_u;

    typedef struct {
        logic        valid;
        logic [63:0] pc;
        logic [31:0] inst;
        logic        wen;
        logic [4:0]  wdest;
        logic [63:0] wdata;
        logic        skip;
        logic [31:0] intr;
        logic [63:0] cyc;
        logic [63:0] ins;
        logic        trap;
        logic        good;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   n_chk = 0;
    int   n_err = 0;
    exp_t m;
    exp_t sb_q[$];

    ysyx_210544_cmt_u_if bus();

    ysyx_210544_cmt_u dut (
        .clk (clk),
        .rst (rst),
        .cmt (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Drive one cycle of stimulus, push the expected result, then compare after the edge.
    task automatic step(input logic r, input logic v, input logic [63:0] pc,
                        input logic [31:0] inst, input logic [4:0] rd, input logic wen,
                        input logic [63:0] wd, input logic skip, input logic [63:0] a0,
                        input logic [31:0] intr);
        exp_t e;
        rst            = r;
        bus.i_cmtvalid = v;
        bus.i_pc       = pc;
        bus.i_inst     = inst;
        bus.i_rd       = rd;
        bus.i_rd_wen   = wen;
        bus.i_rd_wdata = wd;
        bus.i_skipcmt  = skip;
        bus.i_intrNo   = intr;
        for (int i = 0; i < 32; i++) bus.i_regs[i] = 64'h100 + 64'(i);
        bus.i_regs[10] = a0;
        for (int i = 0; i < 16; i++) bus.i_csrs[i] = 64'h3000 + 64'(i);

        if (r) begin
            m = '{default: '0};
        end else begin
            m.valid = v;
            if (v) begin
                m.pc    = pc;
                m.inst  = inst;
                m.wen   = wen && (rd != 5'd0);
                m.wdest = rd;
                m.wdata = wd;
                m.skip  = skip;
            end
            m.intr = intr;
            if (!m.trap) begin
                m.cyc = m.cyc + 64'd1;
                if (v) m.ins = m.ins + 64'd1;
                if (v && inst == 32'h0000006b) begin
                    m.trap = 1'b1;
                    m.good = (a0 == 64'd0);
                end
            end
        end
        sb_q.push_back(m);

        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            chk("sb_empty", 64'd1, 64'd0);
        end else begin
            e = sb_q.pop_front();
            chk("valid", 64'(bus.o_valid),     64'(e.valid));
            chk("pc",    bus.o_pc,             e.pc);
            chk("inst",  64'(bus.o_inst),      64'(e.inst));
            chk("wen",   64'(bus.o_wen),       64'(e.wen));
            chk("wdest", 64'(bus.o_wdest),     64'(e.wdest));
            chk("wdata", bus.o_wdata,          e.wdata);
            chk("skip",  64'(bus.o_skip),      64'(e.skip));
            chk("intr",  64'(bus.o_intrNo),    64'(e.intr));
            chk("cycle", bus.o_cycle_cnt,      e.cyc);
            chk("instr", bus.o_instr_cnt,      e.ins);
            chk("trap",  64'(bus.o_trap),      64'(e.trap));
            chk("good",  64'(bus.o_trap_good), 64'(e.good));
        end
    endtask

    initial begin
        logic [63:0] rpc;
        logic [31:0] rinst;
        m = '{default: '0};

        // Reset held with a commit presented: everything stays zero.
        step(1, 1, 64'h1234, 32'h13, 5'd3, 1, 64'h55, 1, 64'd0, 32'd9);
        step(1, 1, 64'h1238, 32'h6b, 5'd3, 1, 64'h55, 0, 64'd0, 32'd9);
        chk("rst_trap", 64'(bus.o_trap), 64'd0);

        // First cycle after release.
        step(0, 1, 64'h1000, 32'h13, 5'd0, 0, 64'd0, 0, 64'd0, 32'd0);
        chk("rel_cycle", bus.o_cycle_cnt, 64'd1);
        chk("rel_instr", bus.o_instr_cnt, 64'd1);
        chk("rel_valid", 64'(bus.o_valid), 64'd1);

        // addi x1, x0, 1
        step(0, 1, 64'h80000000, 32'h00100093, 5'd1, 1, 64'd1, 0, 64'd0, 32'd0);
        chk("addi_pc",  bus.o_pc, 64'h80000000);
        chk("addi_wen", 64'(bus.o_wen), 64'd1);

        // Write to x0 is suppressed but still counted.
        step(0, 1, 64'h80000004, 32'h00100013, 5'd0, 1, 64'd7, 0, 64'd0, 32'd0);
        chk("x0_wen",   64'(bus.o_wen), 64'd0);
        chk("x0_instr", bus.o_instr_cnt, 64'd3);

        // Idle cycles, including a non-valid halt encoding that must not trap.
        for (int i = 0; i < 3; i++)
            step(0, 0, 64'hdead0000 + 64'(i), 32'h6b, 5'd4, 1, 64'd9, 1, 64'd0, 32'd0);
        chk("idle_pc",   bus.o_pc, 64'h80000004);
        chk("idle_trap", 64'(bus.o_trap), 64'd0);

        // Interrupt pulse with no commit.
        step(0, 0, 64'd0, 32'd0, 5'd0, 0, 64'd0, 0, 64'd0, 32'd7);
        chk("intr_7", 64'(bus.o_intrNo), 64'd7);
        step(0, 0, 64'd0, 32'd0, 5'd0, 0, 64'd0, 0, 64'd0, 32'd0);

        // Random traffic, halt encoding excluded.
        for (int i = 0; i < 30; i++) begin
            rpc   = {$urandom, $urandom};
            rinst = $urandom;
            if (rinst == 32'h6b) rinst = 32'h13;
            step(0, 1'($urandom_range(0, 1)), rpc, rinst, 5'($urandom_range(0, 31)),
                 1'($urandom_range(0, 1)), {$urandom, $urandom}, 1'($urandom_range(0, 1)),
                 64'd0, ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 11)) : 32'd0);
        end

        // Halt with a0 = 5: bad trap, then counters freeze while commits still register.
        step(0, 1, 64'h80001000, 32'h6b, 5'd0, 0, 64'd0, 0, 64'd5, 32'd0);
        chk("bad_trap", 64'(bus.o_trap), 64'd1);
        chk("bad_good", 64'(bus.o_trap_good), 64'd0);
        for (int i = 0; i < 4; i++)
            step(0, 1, 64'h80002000 + 64'(4 * i), (i == 1) ? 32'h6b : 32'h13, 5'd2, 1,
                 64'(i), 0, 64'd0, 32'd0);
        chk("frz_good", 64'(bus.o_trap_good), 64'd0);

        // Mid-run reset with a commit present, then halt with a0 = 0 plus an interrupt.
        step(1, 1, 64'h4, 32'h13, 5'd1, 1, 64'd1, 0, 64'd0, 32'd2);
        step(0, 1, 64'h80000000, 32'h00100093, 5'd1, 1, 64'd1, 1, 64'd0, 32'd0);
        step(0, 1, 64'h80000004, 32'h6b, 5'd0, 0, 64'd0, 0, 64'd0, 32'd3);
        chk("good_trap", 64'(bus.o_trap_good), 64'd1);
        chk("good_intr", 64'(bus.o_intrNo), 64'd3);
        chk("good_cyc",  bus.o_cycle_cnt, 64'd2);
        for (int i = 0; i < 3; i++)
            step(0, i[0], 64'h80000100 + 64'(i), 32'h13, 5'd5, 1, 64'd8, 0, 64'd5, 32'd0);
        chk("frz_instr", bus.o_instr_cnt, 64'd2);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
